// File: rtl/hyperspace_frame_ctrl_if.sv
// Valid/ready stream bundle with end-of-frame marker, shared by the pad-side
// and datapath-side ports of the frame sequencer.
interface hyperspace_frame_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/hyperspace_frame_ctrl.sv
// Frame sequencer between the pad streams and the HyperSpace datapath: frames the
// input stream, bounds frames in flight, checks output framing and reports run status.
module hyperspace_frame_ctrl #(
  parameter int IN_LEN       = 2048,
  parameter int OUT_LEN      = 1536,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 16
) (
  input  logic                   i_clock,
  input  logic                   i_resetb,
  input  logic                   i_cfg_start,
  input  logic                   i_cfg_abort,
  input  logic [CNT_W-1:0]       i_cfg_num_frames,
  hyperspace_frame_ctrl_if.slave  s_in,
  hyperspace_frame_ctrl_if.master m_in,
  hyperspace_frame_ctrl_if.slave  s_out,
  hyperspace_frame_ctrl_if.master m_out,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [CNT_W-1:0]       o_frames_out_cnt
);

  localparam int IN_W  = $clog2(IN_LEN + 1);
  localparam int OUT_W = $clog2(OUT_LEN + 1);
  localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_frames_in;
  logic [CNT_W-1:0] r_frames_out;
  logic [IN_W-1:0]  r_in_beat;
  logic [OUT_W-1:0] r_out_beat;
  logic [IF_W-1:0]  r_inflight;
  logic             r_done;
  logic             r_err;

  logic             w_run;
  logic             w_out_en;
  logic             w_credit;
  logic             w_in_gate;
  logic             w_in_hs;
  logic             w_in_frame;
  logic             w_out_hs;
  logic             w_out_final;
  logic             w_out_err;
  logic             w_out_frame;
  logic [CNT_W-1:0] w_frames_in_nxt;
  logic [CNT_W-1:0] w_frames_out_nxt;

  // Credit is checked only at a frame boundary so an accepted frame always completes.
  assign w_run     = (r_state == S_RUN);
  assign w_out_en  = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_credit  = (r_inflight < IF_W'(MAX_INFLIGHT)) && (r_frames_in < r_num);
  assign w_in_gate = w_run && ((r_in_beat != '0) || w_credit);

  assign m_in.valid = s_in.valid & w_in_gate;
  assign s_in.ready = m_in.ready & w_in_gate;
  assign m_in.data  = s_in.data;
  assign m_in.last  = (r_in_beat == IN_W'(IN_LEN - 1));

  assign m_out.valid = s_out.valid & w_out_en;
  assign s_out.ready = m_out.ready & w_out_en;
  assign m_out.data  = s_out.data;
  assign m_out.last  = s_out.last;

  assign w_in_hs     = s_in.valid & s_in.ready;
  assign w_in_frame  = w_in_hs & m_in.last;
  assign w_out_hs    = s_out.valid & s_out.ready;
  assign w_out_final = (r_out_beat == OUT_W'(OUT_LEN - 1));
  // An output beat with no frame in flight or misplaced last is a framing error.
  assign w_out_err   = w_out_hs && ((s_out.last != w_out_final) ||
                                    ((r_inflight == '0) && (r_out_beat == '0)));
  assign w_out_frame = w_out_hs & w_out_final & s_out.last & ~w_out_err;

  assign w_frames_in_nxt  = r_frames_in + CNT_W'(w_in_frame);
  assign w_frames_out_nxt = r_frames_out + CNT_W'(w_out_frame);

  assign o_busy           = w_out_en;
  assign o_done           = r_done;
  assign o_err            = r_err;
  assign o_frames_out_cnt = r_frames_out;

  always_ff @(posedge i_clock or negedge i_resetb) begin
    if (!i_resetb) begin
      r_state      <= S_IDLE;
      r_num        <= '0;
      r_frames_in  <= '0;
      r_frames_out <= '0;
      r_in_beat    <= '0;
      r_out_beat   <= '0;
      r_inflight   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_cfg_abort) begin
        r_state      <= S_IDLE;
        r_frames_in  <= '0;
        r_frames_out <= '0;
        r_in_beat    <= '0;
        r_out_beat   <= '0;
        r_inflight   <= '0;
        r_err        <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (i_cfg_start) begin
              r_frames_in  <= '0;
              r_frames_out <= '0;
              r_in_beat    <= '0;
              r_out_beat   <= '0;
              r_inflight   <= '0;
              r_err        <= 1'b0;
              r_num        <= i_cfg_num_frames;
              if (i_cfg_num_frames == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_RUN;
              end
            end
          end
          S_RUN, S_DRAIN: begin
            if (w_in_hs) begin
              r_in_beat <= m_in.last ? '0 : r_in_beat + 1'b1;
            end
            if (w_out_hs) begin
              r_out_beat <= w_out_final ? '0 : r_out_beat + 1'b1;
            end
            r_frames_in  <= w_frames_in_nxt;
            r_frames_out <= w_frames_out_nxt;
            r_inflight   <= r_inflight + IF_W'(w_in_frame) - IF_W'(w_out_frame);
            if (w_out_err) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if ((w_frames_in_nxt == r_num) && (w_frames_out_nxt == r_num)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_frames_in_nxt == r_num) begin
              r_state <= S_DRAIN;
            end
          end
          S_ERR: r_state <= S_ERR;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
